// File: rtl/seg7_mux_counter.sv
// rtl/seg7_mux_counter.sv - multi-digit up/down counter with time-multiplexed 7-segment drive
module seg7_mux_counter #(
    parameter int NUM_DIGITS  = 4,
    parameter int BASE        = 10,
    parameter int TICK_DIV    = 50000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [6:0]              cathodeOutput,
    output logic [NUM_DIGITS-1:0]   anodeOutput,
    output logic                    tick,
    output logic                    carry_out
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]    MAX_DIGIT = 4'(BASE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] SCAN_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_DIGITS - 1);

    logic [TW-1:0]           tickCnt;
    logic [RW-1:0]           scanCnt;
    logic [SW-1:0]           scanSel;
    logic                    step;
    logic                    wrapAll;
    logic                    chain;
    logic [3:0]              curNibble;
    logic [3:0]              selDigit;
    logic [4*NUM_DIGITS-1:0] nextDigits;
    logic [4*NUM_DIGITS-1:0] loadDigits;

    function automatic logic [6:0] decodeSeg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (BASE == 10 && d > 4'd9) s = 7'b1111111;
        return s;
    endfunction

    assign step = en && !load && (tickCnt == TICK_LAST);

    // Ripple the +/-1 through the digits; chain still set at the end means every digit wrapped.
    always_comb begin
        nextDigits = digits;
        chain      = 1'b1;
        curNibble  = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            curNibble = digits[4*i +: 4];
            if (chain) begin
                if (up) begin
                    if (curNibble == MAX_DIGIT) begin
                        nextDigits[4*i +: 4] = 4'd0;
                    end else begin
                        nextDigits[4*i +: 4] = curNibble + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (curNibble == 4'd0) begin
                        nextDigits[4*i +: 4] = MAX_DIGIT;
                    end else begin
                        nextDigits[4*i +: 4] = curNibble - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
        wrapAll = chain;
    end

    always_comb begin
        loadDigits = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > MAX_DIGIT) loadDigits[4*i +: 4] = MAX_DIGIT;
        end
    end

    assign selDigit = digits[{scanSel, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt       <= '0;
            digits        <= '0;
            tick          <= 1'b0;
            carry_out     <= 1'b0;
            scanCnt       <= '0;
            scanSel       <= '0;
            anodeOutput   <= '1;
            cathodeOutput <= 7'b1111111;
        end else begin
            if (load) begin
                tickCnt   <= '0;
                digits    <= loadDigits;
                tick      <= 1'b0;
                carry_out <= 1'b0;
            end else begin
                tick      <= step;
                carry_out <= step && wrapAll;
                if (en) tickCnt <= (tickCnt == TICK_LAST) ? '0 : tickCnt + TW'(1);
                if (step) digits <= nextDigits;
            end

            if (scanCnt == SCAN_LAST) begin
                scanCnt <= '0;
                scanSel <= (scanSel == SEL_LAST) ? '0 : scanSel + SW'(1);
            end else begin
                scanCnt <= scanCnt + RW'(1);
            end

            // Anode and cathode come from the same pre-edge select so they never disagree.
            anodeOutput   <= ~(NUM_DIGITS'(1) << scanSel);
            cathodeOutput <= decodeSeg(selDigit);
        end
    end
endmodule

// File: doc/seg7_mux_counter.md
Name: seg7_mux_counter

Overview:
Parametrised multi-digit up/down counter driving a time-multiplexed common-anode 7-segment display.
- Steps once every TICK_DIV clocks, in decimal or hex, with cascaded carry/borrow across NUM_DIGITS digits.
- Supports parallel load and enable.
- Scans the digits with an active-low one-hot anode bus, one digit every REFRESH_DIV clocks.
- Sits between board-level display pins and control logic that needs a visible counter or stopwatch.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8)
BASE, 10, per-digit radix, 10 or 16
TICK_DIV, 50000000, clocks per count step (>=2)
REFRESH_DIV, 100000, clocks each digit stays selected during scan (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable; tick divider runs only when high
up  input  1  1 = increment, 0 = decrement; sampled on the step cycle
load  input  1  one-cycle parallel load strobe
load_val  input  4*NUM_DIGITS  packed digit values, digit 0 in [3:0]
digits  output  4*NUM_DIGITS  current counter value, packed like load_val
cathodeOutput  output  7  segments {a,b,c,d,e,f,g}, active low
anodeOutput  output  NUM_DIGITS  digit select, active low, one-hot-zero
tick  output  1  one-cycle pulse on every count step
carry_out  output  1  one-cycle pulse when the full counter wraps

Behaviour:
- Reset (rst high at an edge):
  - tick divider = 0; digits = 0; scan divider = 0; scan select = 0.
  - cathodeOutput = 7'b1111111; anodeOutput = all ones.
  - tick = 0; carry_out = 0.
- Tick divider: counts 0..TICK_DIV-1 while en = 1 and holds while en = 0.
  - On the cycle it equals TICK_DIV-1 with en = 1, a step occurs and the divider returns to 0.
  - First step comes TICK_DIV enabled cycles after reset.
- Step, up = 1: digit 0 increments. A digit at BASE-1 wraps to 0 and carries into the next digit.
- Step, up = 0: digit 0 decrements. A digit at 0 wraps to BASE-1 and borrows from the next digit.
- tick is registered and high exactly one cycle, the cycle after the step edge, coincident with the new digits value.
- carry_out goes high in that same cycle only when every digit wrapped:
  - all BASE-1 -> all 0 when counting up;
  - all 0 -> all BASE-1 when counting down.
- Load: load = 1 has priority over a step in the same cycle.
  - digits take load_val on the next edge; each nibble >= BASE is clamped to BASE-1.
  - Tick divider resets to 0; tick and carry_out stay 0 that cycle.
  - Load works regardless of en.
- digits is a direct register output; it updates on the edge following a step or load.
- Scan: scan divider free-runs 0..REFRESH_DIV-1, independent of en.
  - At REFRESH_DIV-1, scan select advances (NUM_DIGITS-1 wraps to 0).
- Display outputs: registered from the select and digit value of the previous cycle, giving one clock of latency.
  - anodeOutput = ~(1 << select).
  - cathodeOutput = decode(digit[select]); anode and cathode always change on the same edge.
  - First cycle after reset release: anodeOutput = ...1110 and cathodeOutput shows digit 0.
- Decode (abcdefg, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - With BASE = 10, values 10..15 decode to 1111111 (blank).
- Reset mid-step or mid-scan: reset wins; all state returns to the reset values above on that edge.
- Dividers need ceil(log2(TICK_DIV)) and ceil(log2(REFRESH_DIV)) bits; no overflow past terminal count.

Test Plan:
- BASE=10, NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=3, en=1, up=1: after reset, 40 clocks -> digits=16'h0010; tick pulses every 4th cycle; carry_out never high.
- Load 16'h9998, up=1, 8 more clocks -> digits 9999 then 0000; carry_out and tick both high one cycle on the 0000 step.
- Load 16'h0000, up=0, one step -> digits=16'h9999, carry_out pulse. With BASE=16, same stimulus -> 16'hFFFF.
- Load 16'h12C4 with BASE=10 -> digits=16'h1294 (nibble clamped). With load and a step in the same cycle -> loaded value, tick=0, next step 4 cycles later.
- Scan check: after reset, anodeOutput sequence 1110,1101,1011,0111 with 3-cycle dwell; cathodeOutput matches the decode of the active digit with 1-cycle latency. With BASE=10 and an out-of-range digit forced via BASE=16 instance comparison -> blank 1111111.
- en=0 for 10 cycles mid-divider -> digits and the divider hold, scan continues. rst pulsed mid-count -> next cycle digits=0 and outputs at reset values.
